// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store controller: access types, error codes,
// controller state and the wait-counter width.
package lsu_pkg;

    localparam logic [1:0] RW_BYTE     = 2'b00;
    localparam logic [1:0] RW_HALF     = 2'b01;
    localparam logic [1:0] RW_WORD     = 2'b10;
    localparam int         RW_UNSIGNED = 2;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_RANGE    = 2'b10;
    localparam logic [1:0] ERR_TYPE     = 2'b11;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } lsu_state_e;

    function automatic logic [2:0] rw_size(input logic [1:0] size_code);
        case (size_code)
            RW_BYTE: rw_size = 3'd1;
            RW_HALF: rw_size = 3'd2;
            default: rw_size = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_req_chk.sv
// Combinational request checker: classifies (wr, type, addr) into an error code
// with priority illegal type > misaligned > out of range.
module lsu_req_chk
    import lsu_pkg::*;
#(
    parameter logic [31:0] MEM_BASE  = 32'h8000_0000,
    parameter int unsigned MEM_BYTES = 32768
) (
    input  logic        wr,
    input  logic [2:0]  rw_type,
    input  logic [31:0] addr,
    output logic [1:0]  err
);

    logic        illegal;
    logic        misaligned;
    logic        out_of_range;
    logic [32:0] last_addr;
    logic [32:0] limit;

    always_comb begin
        illegal    = (rw_type[1:0] == 2'b11) || (wr && rw_type[RW_UNSIGNED]);
        misaligned = ((rw_type[1:0] == RW_HALF) && addr[0]) ||
                     ((rw_type[1:0] == RW_WORD) && (addr[1:0] != 2'b00));
        // 33-bit sum so an access near 2^32 cannot wrap back into range.
        last_addr    = {1'b0, addr} + {30'd0, rw_size(rw_type[1:0])} - 33'd1;
        limit        = {1'b0, MEM_BASE} + 33'(MEM_BYTES);
        out_of_range = (addr < MEM_BASE) || (last_addr >= limit);

        if (illegal)           err = ERR_TYPE;
        else if (misaligned)   err = ERR_MISALIGN;
        else if (out_of_range) err = ERR_RANGE;
        else                   err = ERR_OK;
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one request per handshake, drives the mem_ddr
// data port for WAIT_CYCLES cycles, then holds a registered response until taken.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] MEM_BASE    = 32'h8000_0000,
    parameter int unsigned MEM_BYTES   = 32768
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic        mem_wr_en,
    output logic [2:0]  mem_rw_type,
    output logic [31:0] mem_data_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    output lsu_state_e  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both
    // high; valid never depends on ready, and payload is stable while valid waits.

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic             wr_q, wr_d;
    logic [2:0]       type_q, type_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;
    logic [1:0]       resp_err_q, resp_err_d;
    logic [1:0]       chk_err;

    lsu_req_chk #(
        .MEM_BASE  (MEM_BASE),
        .MEM_BYTES (MEM_BYTES)
    ) u_chk (
        .wr      (req_wr),
        .rw_type (req_type),
        .addr    (req_addr),
        .err     (chk_err)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        first_d      = first_q;
        wr_d         = wr_q;
        type_d       = type_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    wr_d    = req_wr;
                    type_d  = req_type;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (chk_err != ERR_OK) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = 32'd0;
                        resp_err_d   = chk_err;
                    end else begin
                        state_d = ST_ACCESS;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                        first_d = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                first_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = wr_q ? 32'd0 : mem_data_out;
                    resp_err_d   = ERR_OK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            first_q      <= 1'b0;
            wr_q         <= 1'b0;
            type_q       <= 3'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            first_q      <= first_d;
            wr_q         <= wr_d;
            type_q       <= type_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // rstn gating keeps a store from committing on an edge that samples reset.
    assign mem_wr_en     = wr_q & first_q & (state_q == ST_ACCESS) & rstn;
    assign mem_rw_type   = type_q;
    assign mem_data_addr = addr_q;
    assign mem_data_in   = wdata_q;
    assign req_ready     = (state_q == ST_IDLE);
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;
    assign dbg_state     = state_q;

endmodule
